// File: rtl/fifo_w_serializer.sv
// Write-side feeder for the async FIFO: splits IN_WIDTH words into DATA_WIDTH lanes, one FIFO write per lane.
// Optional SER_MSB_FIRST_EN sends the most significant lane first; the default build sends LSB first.
module fifo_w_serializer #(
  parameter int IN_WIDTH   = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  fifo_w_clk_i,
  input  logic                  rst_n_i,
  input  logic                  src_valid_i,
  input  logic [IN_WIDTH-1:0]   src_data_i,
  input  logic                  src_last_i,
  output logic                  src_ready_o,
  output logic                  fifo_w_req_o,
  output logic [DATA_WIDTH-1:0] fifo_w_data_o,
  input  logic                  fifo_w_full_i,
  output logic [15:0]           byte_cnt_o,
  output logic                  frame_done_o
);

  localparam int RATIO = IN_WIDTH / DATA_WIDTH;
  localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state;
  logic [LW-1:0]       lane;
  logic [IN_WIDTH-1:0] shreg;
  logic [IN_WIDTH-1:0] shreg_next;
  logic                last_q;
  logic                fire;
  logic                final_lane;

  assign fire       = fifo_w_req_o && !fifo_w_full_i;
  assign final_lane = (state == SEND) && (lane == LAST_LANE);

  // Ready on the final lane lets the next word load on the same edge as the last write.
  assign src_ready_o = (state == IDLE) || (final_lane && !fifo_w_full_i);

`ifdef SER_MSB_FIRST_EN
  assign fifo_w_data_o = shreg[IN_WIDTH-1 -: DATA_WIDTH];
  assign shreg_next    = shreg << DATA_WIDTH;
`else
  assign fifo_w_data_o = shreg[DATA_WIDTH-1:0];
  assign shreg_next    = shreg >> DATA_WIDTH;
`endif

  always_ff @(posedge fifo_w_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      lane         <= '0;
      shreg        <= '0;
      last_q       <= 1'b0;
      fifo_w_req_o <= 1'b0;
      byte_cnt_o   <= '0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;

      // Counter follows the outgoing word even when a new word loads on the same edge.
      if (fire) begin
        if (lane == LAST_LANE && last_q) begin
          byte_cnt_o   <= '0;
          frame_done_o <= 1'b1;
        end else if (byte_cnt_o != 16'hFFFF) begin
          byte_cnt_o <= byte_cnt_o + 16'd1;
        end
      end

      case (state)
        IDLE: begin
          if (src_valid_i) begin
            shreg        <= src_data_i;
            last_q       <= src_last_i;
            lane         <= '0;
            fifo_w_req_o <= 1'b1;
            state        <= SEND;
          end
        end
        SEND: begin
          if (fire) begin
            if (lane != LAST_LANE) begin
              lane  <= lane + 1'b1;
              shreg <= shreg_next;
            end else if (src_valid_i) begin
              shreg  <= src_data_i;
              last_q <= src_last_i;
              lane   <= '0;
            end else begin
              fifo_w_req_o <= 1'b0;
              state        <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_w_serializer.sv
// Directed bench for fifo_w_serializer: vector table for streaming/stall cases, hand sequence for mid-word reset.
module tb_fifo_w_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        src_valid;
  logic [31:0] src_data;
  logic        src_last;
  logic        src_ready;
  logic        fifo_w_req;
  logic [7:0]  fifo_w_data;
  logic        fifo_w_full;
  logic [15:0] byte_cnt;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_w_serializer #(.IN_WIDTH(32), .DATA_WIDTH(8)) dut (
    .fifo_w_clk_i  (clk),
    .rst_n_i       (rst_n),
    .src_valid_i   (src_valid),
    .src_data_i    (src_data),
    .src_last_i    (src_last),
    .src_ready_o   (src_ready),
    .fifo_w_req_o  (fifo_w_req),
    .fifo_w_data_o (fifo_w_data),
    .fifo_w_full_i (fifo_w_full),
    .byte_cnt_o    (byte_cnt),
    .frame_done_o  (frame_done)
  );

  typedef struct {
    logic        vld;
    logic [31:0] dat;
    logic        lst;
    logic        full;
    logic        rdy;
    logic        req;
    logic [7:0]  d;
    logic [15:0] cnt;
    logic        done;
  } vec_t;

  vec_t vecs[64];
  int   nv = 0;

  // Expected byte for lane k of word w in the build's lane order.
  function automatic logic [7:0] ln(input logic [31:0] w, input int k);
`ifdef SER_MSB_FIRST_EN
    return w[8*(3-k) +: 8];
`else
    return w[8*k +: 8];
`endif
  endfunction

  task automatic add(input logic vld, input logic [31:0] dat, input logic lst, input logic full,
                     input logic rdy, input logic req, input logic [7:0] d,
                     input logic [15:0] cnt, input logic done);
    vecs[nv] = '{vld, dat, lst, full, rdy, req, d, cnt, done};
    nv++;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  localparam logic [31:0] W1 = 32'h44332211;
  localparam logic [31:0] W0 = 32'h03020100;
  localparam logic [31:0] W2 = 32'h07060504;
  localparam logic [31:0] W3 = 32'hAABBCCDD;
  localparam logic [31:0] W4 = 32'h0D0C0B0A;

  initial begin
    rst_n       = 1'b0;
    src_valid   = 1'b0;
    src_data    = '0;
    src_last    = 1'b0;
    fifo_w_full = 1'b0;

    // Single word, no full
    add(1, W1, 1, 0,  1, 0, 8'h00,       0, 0);
    add(0, 0,  0, 0,  0, 1, ln(W1, 0),   0, 0);
    add(0, 0,  0, 0,  0, 1, ln(W1, 1),   1, 0);
    add(0, 0,  0, 0,  0, 1, ln(W1, 2),   2, 0);
    add(0, 0,  0, 0,  1, 1, ln(W1, 3),   3, 0);
    add(0, 0,  0, 0,  1, 0, 8'h00,       0, 1);
    // Back-to-back words, no bubble
    add(1, W0, 0, 0,  1, 0, 8'h00,       0, 0);
    add(1, W2, 1, 0,  0, 1, ln(W0, 0),   0, 0);
    add(1, W2, 1, 0,  0, 1, ln(W0, 1),   1, 0);
    add(1, W2, 1, 0,  0, 1, ln(W0, 2),   2, 0);
    add(1, W2, 1, 0,  1, 1, ln(W0, 3),   3, 0);
    add(0, 0,  0, 0,  0, 1, ln(W2, 0),   4, 0);
    add(0, 0,  0, 0,  0, 1, ln(W2, 1),   5, 0);
    add(0, 0,  0, 0,  0, 1, ln(W2, 2),   6, 0);
    add(0, 0,  0, 0,  1, 1, ln(W2, 3),   7, 0);
    // Full stall on lane 2
    add(1, W1, 1, 0,  1, 0, 8'h00,       0, 1);
    add(0, 0,  0, 0,  0, 1, ln(W1, 0),   0, 0);
    add(0, 0,  0, 0,  0, 1, ln(W1, 1),   1, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 1, 0, 1, ln(W1, 2),   2, 0);
    add(0, 0,  0, 0,  0, 1, ln(W1, 2),   2, 0);
    add(0, 0,  0, 0,  1, 1, ln(W1, 3),   3, 0);
    // Full on final lane while a new word waits
    add(1, W1, 1, 0,  1, 0, 8'h00,       0, 1);
    add(0, 0,  0, 0,  0, 1, ln(W1, 0),   0, 0);
    add(0, 0,  0, 0,  0, 1, ln(W1, 1),   1, 0);
    add(0, 0,  0, 0,  0, 1, ln(W1, 2),   2, 0);
    add(1, W3, 1, 1,  0, 1, ln(W1, 3),   3, 0);
    add(1, W3, 1, 1,  0, 1, ln(W1, 3),   3, 0);
    add(1, W3, 1, 0,  1, 1, ln(W1, 3),   3, 0);
    add(0, 0,  0, 0,  0, 1, ln(W3, 0),   0, 1);
    add(0, 0,  0, 0,  0, 1, ln(W3, 1),   1, 0);
    add(0, 0,  0, 0,  0, 1, ln(W3, 2),   2, 0);
    add(0, 0,  0, 0,  1, 1, ln(W3, 3),   3, 0);
    add(0, 0,  0, 0,  1, 0, 8'h00,       0, 1);
    add(0, 0,  0, 0,  1, 0, 8'h00,       0, 0);

    #12;
    chk("reset_rdy",  -1, 32'(src_ready),   32'd1);
    chk("reset_req",  -1, 32'(fifo_w_req),  32'd0);
    chk("reset_data", -1, 32'(fifo_w_data), 32'd0);
    chk("reset_cnt",  -1, 32'(byte_cnt),    32'd0);
    chk("reset_done", -1, 32'(frame_done),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      src_valid   = vecs[i].vld;
      src_data    = vecs[i].dat;
      src_last    = vecs[i].lst;
      fifo_w_full = vecs[i].full;
      #1;
      chk("src_ready", i, 32'(src_ready),  32'(vecs[i].rdy));
      chk("req",       i, 32'(fifo_w_req), 32'(vecs[i].req));
      if (vecs[i].req)
        chk("data", i, 32'(fifo_w_data), 32'(vecs[i].d));
      chk("byte_cnt",   i, 32'(byte_cnt),   32'(vecs[i].cnt));
      chk("frame_done", i, 32'(frame_done), 32'(vecs[i].done));
    end

    // Reset mid-word after two fires
    @(negedge clk);
    src_valid = 1'b1; src_data = W1; src_last = 1'b1; fifo_w_full = 1'b0;
    @(negedge clk);
    src_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_data", 100, 32'(fifo_w_data), 32'(ln(W1, 2)));
    chk("pre_rst_cnt",  100, 32'(byte_cnt),    32'd2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req",  101, 32'(fifo_w_req),  32'd0);
    chk("async_rst_data", 101, 32'(fifo_w_data), 32'd0);
    chk("async_rst_rdy",  101, 32'(src_ready),   32'd1);
    chk("async_rst_cnt",  101, 32'(byte_cnt),    32'd0);
    chk("async_rst_done", 101, 32'(frame_done),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    src_valid = 1'b1; src_data = W4; src_last = 1'b1;
    #1;
    chk("post_rst_rdy", 102, 32'(src_ready),  32'd1);
    chk("post_rst_req", 102, 32'(fifo_w_req), 32'd0);
    @(negedge clk);
    src_valid = 1'b0;
    #1;
    chk("post_rst_lane0", 103, 32'(fifo_w_data), 32'(ln(W4, 0)));
    chk("post_rst_cnt0",  103, 32'(byte_cnt),    32'd0);
    @(negedge clk);
    #1;
    chk("post_rst_lane1", 104, 32'(fifo_w_data), 32'(ln(W4, 1)));
    chk("post_rst_cnt1",  104, 32'(byte_cnt),    32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
